// File: rtl/bsp_pkg.sv
// Shared types for the bit-serial row sequencer: op codes, FA one-hot codes and the
// buffered command record.
package bsp_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_ADC  = 3'd2,
        OP_AND  = 3'd3,
        OP_XOR  = 3'd4,
        OP_OR   = 3'd5,
        OP_COPY = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    localparam logic [3:0] FA_SUM = 4'b0001;
    localparam logic [3:0] FA_AND = 4'b0010;
    localparam logic [3:0] FA_XOR = 4'b0100;
    localparam logic [3:0] FA_OR  = 4'b1000;

    // Field widths are upper bounds; the top zero-extends its RW/REPW-wide inputs into them.
    localparam int ROW_W = 8;
    localparam int REP_W = 8;

    typedef struct packed {
        op_e              op;
        logic [ROW_W-1:0] acc;
        logic [ROW_W-1:0] src;
        logic [ROW_W-1:0] dst;
        logic [REP_W-1:0] rep;
    } cmd_t;

endpackage

// File: rtl/bsp_cmd_fifo.sv
// Small command FIFO for the row sequencer; pointers carry an extra wrap bit so
// full and empty are distinguishable without a counter.
module bsp_cmd_fifo
    import bsp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    cmd_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bitserial_row_sequencer.sv
// Row-level command sequencer for the reg_cell array: buffers commands and drives
// registered one-hot bus selects, write enables, FA op and carry-in, one operation per cycle.
module bitserial_row_sequencer
    import bsp_pkg::*;
#(
    parameter int NROWS = 8,
    parameter int RW    = 3,
    parameter int DEPTH = 4,
    parameter int REPW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RW-1:0]    cmd_acc,
    input  logic [RW-1:0]    cmd_src,
    input  logic [RW-1:0]    cmd_dst,
    input  logic [REPW-1:0]  cmd_rep,
    input  logic             carry_msb_in,
    output logic [NROWS-1:0] rd_sel_up,
    output logic [NROWS-1:0] rd_sel_dn,
    output logic [NROWS-1:0] wr_sel_up,
    output logic [NROWS-1:0] wr_sel_dn,
    output logic [NROWS-1:0] wr_en,
    output logic [3:0]       op_fa,
    output logic             c_in,
    output logic             carry_flag,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(NROWS);

    function automatic logic [NROWS-1:0] onehot(input logic [ROW_W-1:0] idx);
        return {{(NROWS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic row_bad(input cmd_t c);
        return (c.acc >= ROW_LIM) || (c.src >= ROW_LIM) || (c.dst >= ROW_LIM);
    endfunction

    state_e           state_q, state_d;
    cmd_t             cur_q, cur_d;
    logic [REP_W-1:0] rem_q, rem_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             c_in_q, c_in_d;
    logic [3:0]       op_fa_q, op_fa_d;
    logic [NROWS-1:0] rd_sel_up_q, rd_sel_up_d;
    logic [NROWS-1:0] rd_sel_dn_q, rd_sel_dn_d;
    logic [NROWS-1:0] wr_sel_up_q, wr_sel_up_d;
    logic [NROWS-1:0] wr_sel_dn_q, wr_sel_dn_d;
    logic [NROWS-1:0] wr_en_q, wr_en_d;

    cmd_t push_cmd;
    cmd_t fifo_head;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_pop;
    logic issue;

    always_comb begin
        push_cmd     = '0;
        push_cmd.op  = op_e'(cmd_op);
        push_cmd.acc = ROW_W'(cmd_acc);
        push_cmd.src = ROW_W'(cmd_src);
        push_cmd.dst = ROW_W'(cmd_dst);
        push_cmd.rep = REP_W'(cmd_rep);
    end

    bsp_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // rem_q counts the control cycles still owed to cur_q, including the one on the outputs now.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        issue       = 1'b0;
        done_d      = 1'b0;
        c_in_d      = 1'b0;
        op_fa_d     = '0;
        rd_sel_up_d = '0;
        rd_sel_dn_d = '0;
        wr_sel_up_d = '0;
        wr_sel_dn_d = '0;
        wr_en_d     = '0;

        if (state_q == S_EXEC && (cur_q.op == OP_ADD || cur_q.op == OP_ADC) && !row_bad(cur_q))
            carry_d = carry_msb_in;

        if (state_q == S_EXEC && rem_q > REP_ONE) begin
            issue = 1'b1;
            rem_d = rem_q - REP_ONE;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            issue    = 1'b1;
            cur_d    = fifo_head;
            rem_d    = (fifo_head.rep == '0) ? REP_ONE : fifo_head.rep;
            state_d  = S_EXEC;
        end else begin
            state_d = S_IDLE;
        end

        // ADC takes carry_d so a repetition sees the carry produced by the cycle just ending.
        if (issue) begin
            done_d = (rem_d == REP_ONE);
            if (row_bad(cur_d)) begin
                err_d = 1'b1;
            end else begin
                case (cur_d.op)
                    OP_ADD, OP_ADC, OP_AND, OP_XOR, OP_OR, OP_COPY: begin
                        if (cur_d.op != OP_COPY) begin
                            if (cur_d.src <= cur_d.acc) rd_sel_up_d = onehot(cur_d.src);
                            else                        rd_sel_dn_d = onehot(cur_d.src);
                        end
                        if (cur_d.dst >= cur_d.acc) wr_sel_up_d = onehot(cur_d.acc);
                        else                        wr_sel_dn_d = onehot(cur_d.acc);
                        wr_en_d = onehot(cur_d.dst);
                        case (cur_d.op)
                            OP_AND:  op_fa_d = FA_AND;
                            OP_XOR:  op_fa_d = FA_XOR;
                            OP_OR:   op_fa_d = FA_OR;
                            OP_COPY: op_fa_d = FA_OR;
                            default: op_fa_d = FA_SUM;
                        endcase
                        c_in_d = (cur_d.op == OP_ADC) ? carry_d : 1'b0;
                    end
                    OP_CLR:  wr_en_d = onehot(cur_d.dst);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            c_in_q      <= 1'b0;
            op_fa_q     <= '0;
            rd_sel_up_q <= '0;
            rd_sel_dn_q <= '0;
            wr_sel_up_q <= '0;
            wr_sel_dn_q <= '0;
            wr_en_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            done_q      <= done_d;
            c_in_q      <= c_in_d;
            op_fa_q     <= op_fa_d;
            rd_sel_up_q <= rd_sel_up_d;
            rd_sel_dn_q <= rd_sel_dn_d;
            wr_sel_up_q <= wr_sel_up_d;
            wr_sel_dn_q <= wr_sel_dn_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign busy       = (state_q == S_EXEC) || !fifo_empty;
    assign rd_sel_up  = rd_sel_up_q;
    assign rd_sel_dn  = rd_sel_dn_q;
    assign wr_sel_up  = wr_sel_up_q;
    assign wr_sel_dn  = wr_sel_dn_q;
    assign wr_en      = wr_en_q;
    assign op_fa      = op_fa_q;
    assign c_in       = c_in_q;
    assign carry_flag = carry_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bitserial_row_sequencer.sv
// Directed bench for bitserial_row_sequencer (NROWS=8, RW=4 so out-of-range rows can be
// offered); expected values are hand-computed constants.
module tb_bitserial_row_sequencer;
    import bsp_pkg::*;

    localparam int NROWS = 8;
    localparam int RW    = 4;
    localparam int DEPTH = 4;
    localparam int REPW  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [RW-1:0]    cmd_acc;
    logic [RW-1:0]    cmd_src;
    logic [RW-1:0]    cmd_dst;
    logic [REPW-1:0]  cmd_rep;
    logic             carry_msb_in;
    logic [NROWS-1:0] rd_sel_up, rd_sel_dn, wr_sel_up, wr_sel_dn, wr_en;
    logic [3:0]       op_fa;
    logic             c_in, carry_flag, busy, done, err;

    int errors = 0;
    int checks = 0;

    bitserial_row_sequencer #(
        .NROWS(NROWS), .RW(RW), .DEPTH(DEPTH), .REPW(REPW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_acc      (cmd_acc),
        .cmd_src      (cmd_src),
        .cmd_dst      (cmd_dst),
        .cmd_rep      (cmd_rep),
        .carry_msb_in (carry_msb_in),
        .rd_sel_up    (rd_sel_up),
        .rd_sel_dn    (rd_sel_dn),
        .wr_sel_up    (wr_sel_up),
        .wr_sel_dn    (wr_sel_dn),
        .wr_en        (wr_en),
        .op_fa        (op_fa),
        .c_in         (c_in),
        .carry_flag   (carry_flag),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one command for a single clock edge; returns 1 time unit after that edge.
    task automatic applyStimulus(input op_e op, input int acc, input int src, input int dst, input int rep);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_acc   = RW'(acc);
        cmd_src   = RW'(src);
        cmd_dst   = RW'(dst);
        cmd_rep   = REPW'(rep);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_acc = '0; cmd_src = '0;
        cmd_dst = '0; cmd_rep = '0; carry_msb_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(cmd_ready), 32'h1);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);

        // ADD acc=2 src=1 dst=3 into an idle block
        applyStimulus(OP_ADD, 2, 1, 3, 1);
        checkOutput("add_lat_wr_en", 32'(wr_en), 32'h0);
        checkOutput("add_lat_busy", 32'(busy), 32'h1);
        nextCycle();
        checkOutput("add_rd_up", 32'(rd_sel_up), 32'h02);
        checkOutput("add_rd_dn", 32'(rd_sel_dn), 32'h00);
        checkOutput("add_wr_up", 32'(wr_sel_up), 32'h04);
        checkOutput("add_wr_dn", 32'(wr_sel_dn), 32'h00);
        checkOutput("add_wr_en", 32'(wr_en), 32'h08);
        checkOutput("add_op_fa", 32'(op_fa), 32'h1);
        checkOutput("add_c_in", 32'(c_in), 32'h0);
        checkOutput("add_done", 32'(done), 32'h1);
        nextCycle();
        checkOutput("add_after_wr_en", 32'(wr_en), 32'h0);
        checkOutput("add_after_done", 32'(done), 32'h0);
        checkOutput("add_after_busy", 32'(busy), 32'h0);

        // ADD acc=5 src=6 dst=0 uses the down buses
        applyStimulus(OP_ADD, 5, 6, 0, 1);
        nextCycle();
        checkOutput("dn_rd_up", 32'(rd_sel_up), 32'h00);
        checkOutput("dn_rd_dn", 32'(rd_sel_dn), 32'h40);
        checkOutput("dn_wr_dn", 32'(wr_sel_dn), 32'h20);
        checkOutput("dn_wr_up", 32'(wr_sel_up), 32'h00);
        checkOutput("dn_wr_en", 32'(wr_en), 32'h01);

        // CLR dst=7: only the write enable
        applyStimulus(OP_CLR, 0, 0, 7, 1);
        nextCycle();
        checkOutput("clr_wr_en", 32'(wr_en), 32'h80);
        checkOutput("clr_rd_up", 32'(rd_sel_up), 32'h00);
        checkOutput("clr_wr_up", 32'(wr_sel_up), 32'h00);
        checkOutput("clr_op_fa", 32'(op_fa), 32'h0);

        // ADD producing carry 1, then ADC rep=2 whose first repetition produces carry 0
        carry_msb_in = 1'b1;
        applyStimulus(OP_ADD, 1, 0, 1, 1);
        applyStimulus(OP_ADC, 1, 0, 1, 2);
        checkOutput("chain_add_op", 32'(op_fa), 32'h1);
        checkOutput("chain_add_cin", 32'(c_in), 32'h0);
        checkOutput("chain_add_rd", 32'(rd_sel_up), 32'h01);
        nextCycle();
        checkOutput("adc1_cin", 32'(c_in), 32'h1);
        checkOutput("adc1_flag", 32'(carry_flag), 32'h1);
        checkOutput("adc1_done", 32'(done), 32'h0);
        checkOutput("adc1_wr_en", 32'(wr_en), 32'h02);
        carry_msb_in = 1'b0;
        nextCycle();
        checkOutput("adc2_cin", 32'(c_in), 32'h0);
        checkOutput("adc2_done", 32'(done), 32'h1);
        nextCycle();
        checkOutput("adc_end_flag", 32'(carry_flag), 32'h0);
        checkOutput("adc_end_wr_en", 32'(wr_en), 32'h0);

        // XOR rep=3 acc=dst=4 src=2
        applyStimulus(OP_XOR, 4, 2, 4, 3);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("xor%0d_op", i), 32'(op_fa), 32'h4);
            checkOutput($sformatf("xor%0d_rd_up", i), 32'(rd_sel_up), 32'h04);
            checkOutput($sformatf("xor%0d_wr_up", i), 32'(wr_sel_up), 32'h10);
            checkOutput($sformatf("xor%0d_wr_en", i), 32'(wr_en), 32'h10);
            checkOutput($sformatf("xor%0d_done", i), 32'(done), (i == 2) ? 32'h1 : 32'h0);
        end
        nextCycle();
        checkOutput("xor_end_wr_en", 32'(wr_en), 32'h0);

        // OR rep=7 occupies the sequencer while the FIFO fills; the sixth push is dropped
        applyStimulus(OP_OR, 0, 0, 0, 7);
        applyStimulus(OP_AND, 1, 1, 2, 1);
        applyStimulus(OP_COPY, 3, 3, 5, 1);
        applyStimulus(OP_ADD, 7, 3, 1, 1);
        applyStimulus(OP_ADD, 0, 0, 9, 1);
        checkOutput("fill_ready", 32'(cmd_ready), 32'h0);
        applyStimulus(OP_CLR, 0, 0, 6, 1);
        checkOutput("fill_ready2", 32'(cmd_ready), 32'h0);
        checkOutput("or5_op", 32'(op_fa), 32'h8);
        checkOutput("or5_wr_en", 32'(wr_en), 32'h01);
        checkOutput("or5_done", 32'(done), 32'h0);
        nextCycle();
        checkOutput("or6_done", 32'(done), 32'h0);
        nextCycle();
        checkOutput("or7_done", 32'(done), 32'h1);
        checkOutput("or7_op", 32'(op_fa), 32'h8);
        nextCycle();
        checkOutput("and_op", 32'(op_fa), 32'h2);
        checkOutput("and_rd_up", 32'(rd_sel_up), 32'h02);
        checkOutput("and_wr_up", 32'(wr_sel_up), 32'h02);
        checkOutput("and_wr_en", 32'(wr_en), 32'h04);
        checkOutput("and_ready", 32'(cmd_ready), 32'h1);
        nextCycle();
        checkOutput("copy_op", 32'(op_fa), 32'h8);
        checkOutput("copy_rd_up", 32'(rd_sel_up), 32'h00);
        checkOutput("copy_rd_dn", 32'(rd_sel_dn), 32'h00);
        checkOutput("copy_wr_up", 32'(wr_sel_up), 32'h08);
        checkOutput("copy_wr_en", 32'(wr_en), 32'h20);
        nextCycle();
        checkOutput("add7_rd_up", 32'(rd_sel_up), 32'h08);
        checkOutput("add7_wr_dn", 32'(wr_sel_dn), 32'h80);
        checkOutput("add7_wr_en", 32'(wr_en), 32'h02);
        checkOutput("add7_err", 32'(err), 32'h0);
        nextCycle();
        checkOutput("bad_wr_en", 32'(wr_en), 32'h0);
        checkOutput("bad_op", 32'(op_fa), 32'h0);
        checkOutput("bad_done", 32'(done), 32'h1);
        checkOutput("bad_err", 32'(err), 32'h1);
        nextCycle();
        checkOutput("drop_wr_en", 32'(wr_en), 32'h0);
        checkOutput("drop_busy", 32'(busy), 32'h0);
        checkOutput("err_sticky", 32'(err), 32'h1);

        // Asynchronous reset in the middle of a long command
        applyStimulus(OP_OR, 0, 0, 0, 7);
        nextCycle();
        checkOutput("pre_rst_wr_en", 32'(wr_en), 32'h01);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("arst_op_fa", 32'(op_fa), 32'h0);
        checkOutput("arst_wr_sel", 32'(wr_sel_up), 32'h0);
        checkOutput("arst_ready", 32'(cmd_ready), 32'h1);
        checkOutput("arst_busy", 32'(busy), 32'h0);
        checkOutput("arst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("post_rst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("post_rst_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
